// File: rtl/fetch_queue.sv
// fetch_queue: Y86-64 fetch/decode stage feeding a QDEPTH-entry decoded-instruction queue.
// Define FETCH_QUEUE_PRED_EN to follow jXX/call targets instead of the sequential PC.
module fetch_queue #(
    parameter int          IMEM_BYTES = 2048,
    parameter int          QDEPTH     = 2,
    parameter logic [63:0] RESET_PC   = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    input  logic        imem_we,
    input  logic [63:0] imem_waddr,
    input  logic [7:0]  imem_wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [63:0] pc_out,
    output logic        ins_er,
    output logic        adr_er,
    output logic        hlt_er,
    output logic [63:0] fetch_pc
);
    localparam int AW = $clog2(IMEM_BYTES);
    localparam int PW = $clog2(QDEPTH);
    localparam logic [63:0] MEM_END = 64'(IMEM_BYTES);

    typedef struct packed {
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp, pc;
        logic        ins_er, adr_er, hlt_er;
    } entry_t;

    typedef enum logic {RUN, STOP} state_t;

    logic [7:0]   mem [IMEM_BYTES];
    logic [7:0]   b [10];
    entry_t       q [QDEPTH];
    entry_t       e, h;
    state_t       st;
    logic [PW-1:0] wp, rp;
    logic [PW:0]  cnt;
    logic [3:0]   len;
    logic         has_reg, ins, err, full, push, pop;
    logic [63:0]  next_pc;

    function automatic logic [7:0] rd(input logic [63:0] a);
        return a < MEM_END ? mem[a[AW-1:0]] : 8'h00;
    endfunction

    always_ff @(posedge clk)
        if (imem_we && imem_waddr < MEM_END) mem[imem_waddr[AW-1:0]] <= imem_wdata;

    always_comb begin
        for (int i = 0; i < 10; i++) b[i] = rd(fetch_pc + 64'(i));
        e = '0;
        e.icode = b[0][7:4];
        e.ifun = b[0][3:0];
        has_reg = e.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
        len = (e.icode inside {4'h2, 4'h6, 4'hA, 4'hB}) ? 4'd2 :
              (e.icode inside {4'h7, 4'h8}) ? 4'd9 :
              (e.icode inside {4'h3, 4'h4, 4'h5}) ? 4'd10 : 4'd1;
        e.ra = has_reg ? b[1][7:4] : 4'hF;
        e.rb = has_reg ? b[1][3:0] : 4'hF;
        e.valc = (e.icode inside {4'h3, 4'h4, 4'h5}) ? {b[9], b[8], b[7], b[6], b[5], b[4], b[3], b[2]} :
                 (e.icode inside {4'h7, 4'h8}) ? {b[8], b[7], b[6], b[5], b[4], b[3], b[2], b[1]} : 64'h0;
        e.valp = fetch_pc + 64'(len);
        e.pc = fetch_pc;
        ins = e.icode > 4'hB || (e.icode == 4'h6 && e.ifun > 4'h3) ||
              ((e.icode == 4'h2 || e.icode == 4'h7) && e.ifun > 4'h6) ||
              (e.icode <= 4'hB && !(e.icode inside {4'h2, 4'h6, 4'h7}) && e.ifun != 4'h0);
        e.adr_er = fetch_pc >= MEM_END || (e.valp - 64'd1) >= MEM_END;
        e.ins_er = !e.adr_er && ins;
        e.hlt_er = !e.adr_er && !ins && e.icode == 4'h0;
        err = e.adr_er || e.ins_er || e.hlt_er;
`ifdef FETCH_QUEUE_PRED_EN
        next_pc = (e.icode == 4'h7 || e.icode == 4'h8) ? e.valc : e.valp;
`else
        next_pc = e.valp;
`endif
    end

    assign out_valid = cnt != '0;
    assign full = cnt == (PW+1)'(QDEPTH);
    assign pop = out_valid && out_ready && !redirect;
    assign push = st == RUN && !redirect && (!full || pop);

    always_ff @(posedge clk)
        if (push) q[wp] <= e;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            st <= RUN;
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            st <= RUN;
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
                fetch_pc <= next_pc;
                if (err) st <= STOP;
            end
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // Head fields read as zero while the queue is empty.
    assign h = out_valid ? q[rp] : '0;
    assign icode = h.icode;
    assign ifun = h.ifun;
    assign rA = h.ra;
    assign rB = h.rb;
    assign valC = h.valc;
    assign valP = h.valp;
    assign pc_out = h.pc;
    assign ins_er = h.ins_er;
    assign adr_er = h.adr_er;
    assign hlt_er = h.hlt_er;
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter IMEM_BYTES, default 2048, instruction memory size in bytes.
REQ-002 Parameter QDEPTH, default 2, decoded-instruction queue depth (power of two, 2..8).
REQ-003 Parameter RESET_PC, default 0, fetch PC loaded on reset.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 redirect  in  1; redirect_pc  in  64: flush the queue and restart fetch at redirect_pc.
REQ-007 imem_we  in  1; imem_waddr  in  64; imem_wdata  in  8: byte write port for loading instruction memory.
REQ-008 out_valid  out  1; out_ready  in  1: head-of-queue handshake.
REQ-009 icode, ifun, rA, rB  out  4 each: head entry fields.
REQ-010 valC, valP, pc_out  out  64 each: head entry constant, next sequential PC, and instruction PC.
REQ-011 ins_er, adr_er, hlt_er  out  1 each: head entry status flags.
REQ-012 fetch_pc  out  64: current fetch PC.

Function
REQ-013 Instruction lengths by icode: 0,1,9 -> 1 byte; 2,6,A,B -> 2; 7,8 -> 9; 3,4,5 -> 10.
REQ-014 Byte 0 splits as icode=[7:4], ifun=[3:0]; the register byte splits as rA=[7:4], rB=[3:0]; valC is little-endian from byte 2 (icode 3/4/5) or byte 1 (icode 7/8), else 0; rA=rB=F when there is no register byte.
REQ-015 valP SHALL equal PC + length, computed modulo 2^64.
REQ-016 Bytes at addresses >= IMEM_BYTES SHALL read as 0x00.
REQ-017 ins_er is set when icode > B; or ifun > 3 for icode 6; or ifun > 6 for icode 2/7; or ifun != 0 for any other icode.
REQ-018 adr_er is set when PC >= IMEM_BYTES or PC + length - 1 >= IMEM_BYTES; adr_er takes priority over ins_er and hlt_er.
REQ-019 hlt_er is set when icode = 0 and no other error applies.
REQ-020 FSM states are RUN and STOP. In RUN, one entry is pushed per cycle when the queue is not full, or when it is full and a pop occurs that cycle; fetch_pc then advances to the next PC.
REQ-021 An entry with any error flag set is pushed, and the FSM then moves to STOP.
REQ-022 In STOP there are no pushes and fetch_pc holds; the queue keeps draining.
REQ-023 A pop occurs when out_valid && out_ready; out_valid = queue not empty; outputs reflect the head entry combinationally.
REQ-024 When redirect is high: flush the queue, set fetch_pc <= redirect_pc, enter RUN, and make no push or pop that cycle. Redirect has priority over everything except rst.
REQ-025 A push into an empty queue makes out_valid high the next cycle; fetch-to-output latency is 1 cycle.
REQ-026 An imem write lands at the clock edge; a fetch in the same cycle sees the old byte. Writes to addresses >= IMEM_BYTES are ignored.
REQ-027 Queue pointers wrap modulo QDEPTH; the queue never overflows and never pops when empty.

Reset
REQ-028 On rst: fetch_pc=RESET_PC, queue empty, out_valid=0, FSM=RUN. Head outputs read 0 while the queue is empty.
REQ-029 rst overrides redirect and the handshake. Instruction memory contents are not cleared.

Configuration
REQ-030 Macro FETCH_QUEUE_PRED_EN, when defined: next PC = valC for icode 7 (jXX) and icode 8 (call), else valP. An entry with ifun != 0 for icode 7 records the untaken target valP in its valP field.
REQ-031 Without FETCH_QUEUE_PRED_EN: next PC is always valP. Redirect alone corrects control flow.

Verification
REQ-032 Load 30 F3 08 00 00 00 00 00 00 00, 10, 00 at addr 0; out_ready=1 -> entries in order:
  - icode3, rB=3, valC=8, valP=10;
  - icode1, valP=11;
  - icode0 with hlt_er=1, valP=12;
  then STOP and fetch_pc=12.
REQ-033 Hold out_ready=0 with QDEPTH=2 -> exactly 2 entries are queued and fetch_pc stalls. Raising out_ready gives one pop per cycle with no lost or duplicated entry.
REQ-034 Byte 0xC0 at PC 4 -> entry with ins_er=1, pc_out=4, then STOP. Redirect to 0 -> fetch resumes at 0 and out_valid drops for 1 cycle.
REQ-035 irmovq placed at PC 2040 with IMEM_BYTES=2048 -> entry with adr_er=1, then STOP. Redirect to 2048 -> entry with adr_er=1 and icode=0.
REQ-036 With FETCH_QUEUE_PRED_EN, 70 20 00 00 00 00 00 00 00 at 0 -> the next pc_out is 0x20. Without the macro -> the next pc_out is 9.
REQ-037 Assert rst mid-stream with a full queue -> next cycle out_valid=0 and fetch_pc=RESET_PC. Redirect and rst together -> reset wins.
